// File: rtl/axi4l_pkg.sv
// Shared AXI4-Lite types and response codes used by initiators and peripherals.
`timescale 1ns/1ps
package axi4l_pkg;

   typedef logic [31:0] addr_t;
   typedef logic [31:0] data_t;
   typedef logic [3:0]  strb_t;
   typedef logic [1:0]  resp_t;
   typedef logic [2:0]  prot_t;

   localparam resp_t OKAY   = 2'b00;
   localparam resp_t EXOKAY = 2'b01;
   localparam resp_t SLVERR = 2'b10;
   localparam resp_t DECERR = 2'b11;

   function automatic logic resp_is_err(input resp_t r);
      return r != OKAY;
   endfunction

endpackage

// File: rtl/axi4l_if.sv
// AXI4-Lite channel bundle shared by the SoC initiator and its peripherals.
`timescale 1ns/1ps
interface axi4l_if;
   import axi4l_pkg::*;

   logic  aclk;
   logic  aresetn;

   addr_t awaddr;
   prot_t awprot;
   logic  awvalid;
   logic  awready;

   data_t wdata;
   strb_t wstrb;
   logic  wvalid;
   logic  wready;

   resp_t bresp;
   logic  bvalid;
   logic  bready;

   addr_t araddr;
   prot_t arprot;
   logic  arvalid;
   logic  arready;

   data_t rdata;
   resp_t rresp;
   logic  rvalid;
   logic  rready;

   modport master (
      input  aclk, aresetn,
      output awaddr, awprot, awvalid, input awready,
      output wdata, wstrb, wvalid, input wready,
      input  bresp, bvalid, output bready,
      output araddr, arprot, arvalid, input arready,
      input  rdata, rresp, rvalid, output rready
   );

   modport slave (
      input  aclk, aresetn,
      input  awaddr, awprot, awvalid, output awready,
      input  wdata, wstrb, wvalid, output wready,
      output bresp, bvalid, input bready,
      input  araddr, arprot, arvalid, output arready,
      output rdata, rresp, rvalid, input rready
   );

endinterface

// File: rtl/obi_axi4l_master.sv
// OBI request port to AXI4-Lite initiator, one transaction in flight at a time.
// Response returns as a registered one-cycle data_rvalid pulse three cycles after grant at best.
`timescale 1ns/1ps
module obi_axi4l_master
   import axi4l_pkg::*;
#(
   parameter prot_t AXPROT    = 3'b000,
   parameter data_t ERR_RDATA = 32'h0000_0000
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         data_req,
   output logic         data_gnt,
   input  logic         data_we,
   input  logic [3:0]   data_be,
   input  logic [31:0]  data_addr,
   input  logic [31:0]  data_wdata,
   output logic         data_rvalid,
   output logic [31:0]  data_rdata,
   output logic         data_err,
   axi4l_if.master      axi
);

   typedef enum logic [2:0] {IDLE, WRITE, WRESP, READ, RRESP} state_e;

   state_e state_q;
   addr_t  addr_q;
   data_t  wdata_q;
   strb_t  strb_q;
   logic   awvalid_q, wvalid_q, arvalid_q, bready_q, rready_q;
   logic   rvalid_q, err_q;
   data_t  rdata_q;

   // A channel counts as done once its valid has dropped or it handshakes this cycle.
   logic aw_done, w_done;
   assign aw_done = ~awvalid_q | axi.awready;
   assign w_done  = ~wvalid_q  | axi.wready;

   assign data_gnt    = (state_q == IDLE) & data_req;
   assign data_rvalid = rvalid_q;
   assign data_rdata  = rdata_q;
   assign data_err    = err_q;

   assign axi.awaddr  = addr_q;
   assign axi.awprot  = AXPROT;
   assign axi.awvalid = awvalid_q;
   assign axi.wdata   = wdata_q;
   assign axi.wstrb   = strb_q;
   assign axi.wvalid  = wvalid_q;
   assign axi.bready  = bready_q;
   assign axi.araddr  = addr_q;
   assign axi.arprot  = AXPROT;
   assign axi.arvalid = arvalid_q;
   assign axi.rready  = rready_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         strb_q    <= '0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         arvalid_q <= 1'b0;
         bready_q  <= 1'b0;
         rready_q  <= 1'b0;
         rvalid_q  <= 1'b0;
         err_q     <= 1'b0;
         rdata_q   <= '0;
      end else begin
         rvalid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (data_req) begin
                  addr_q  <= data_addr & ~32'h3;
                  wdata_q <= data_wdata;
                  strb_q  <= data_be;
                  if (data_we) begin
                     state_q   <= WRITE;
                     awvalid_q <= 1'b1;
                     wvalid_q  <= 1'b1;
                  end else begin
                     state_q   <= READ;
                     arvalid_q <= 1'b1;
                  end
               end
            end
            WRITE: begin
               if (awvalid_q && axi.awready) awvalid_q <= 1'b0;
               if (wvalid_q && axi.wready)   wvalid_q  <= 1'b0;
               if (aw_done && w_done) begin
                  state_q  <= WRESP;
                  bready_q <= 1'b1;
               end
            end
            WRESP: begin
               if (axi.bvalid) begin
                  state_q  <= IDLE;
                  bready_q <= 1'b0;
                  rvalid_q <= 1'b1;
                  err_q    <= resp_is_err(axi.bresp);
               end
            end
            READ: begin
               if (axi.arready) begin
                  state_q   <= RRESP;
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
               end
            end
            RRESP: begin
               if (axi.rvalid) begin
                  state_q  <= IDLE;
                  rready_q <= 1'b0;
                  rvalid_q <= 1'b1;
                  err_q    <= resp_is_err(axi.rresp);
                  rdata_q  <= resp_is_err(axi.rresp) ? ERR_RDATA : axi.rdata;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_obi_axi4l_master.sv
// Bench: OBI bridge against a timer-like AXI4-Lite slave with per-channel backpressure.
`timescale 1ns/1ps
module tb_obi_axi4l_master;
   import axi4l_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        data_req, data_gnt, data_we, data_rvalid, data_err;
   logic [3:0]  data_be;
   logic [31:0] data_addr, data_wdata, data_rdata;

   always #5 clk = ~clk;

   axi4l_if axi();
   assign axi.aclk    = clk;
   assign axi.aresetn = ~rst;

   obi_axi4l_master #(.AXPROT(3'b000), .ERR_RDATA(32'h0000_0000)) dut (
      .clk(clk), .rst(rst),
      .data_req(data_req), .data_gnt(data_gnt), .data_we(data_we), .data_be(data_be),
      .data_addr(data_addr), .data_wdata(data_wdata),
      .data_rvalid(data_rvalid), .data_rdata(data_rdata), .data_err(data_err),
      .axi(axi)
   );

   int checks = 0, failures = 0, cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic data_t merge(input data_t o, input data_t n, input strb_t s);
      data_t r = o;
      for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
      return r;
   endfunction

   function automatic int imax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // ---------------- slave model: 0x0 MTIME (RO), 0x8 MTIMECMP, 0xC scratch, else SLVERR
   int    aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
   int    aw_wait, w_wait, b_wait, ar_wait, r_wait;
   logic  aw_got, w_got, b_pend, r_pend;
   addr_t aw_cap;
   data_t w_cap, rdata_s, mtime_s, cmp_s, scr_s;
   strb_t ws_cap;
   resp_t bresp_s, rresp_s;

   assign axi.awready = !aw_got && !b_pend && (aw_wait >= aw_dly);
   assign axi.wready  = !w_got && !b_pend && (w_wait >= w_dly);
   assign axi.bvalid  = b_pend && (b_wait >= b_dly);
   assign axi.bresp   = bresp_s;
   assign axi.arready = !r_pend && (ar_wait >= ar_dly);
   assign axi.rvalid  = r_pend && (r_wait >= r_dly);
   assign axi.rdata   = rdata_s;
   assign axi.rresp   = rresp_s;

   always @(posedge clk) begin : slave
      logic  a_now, w_now;
      addr_t wa;
      data_t wd;
      strb_t wsb;
      if (rst) begin
         aw_got <= 0; w_got <= 0; b_pend <= 0; r_pend <= 0;
         aw_wait <= 0; w_wait <= 0; b_wait <= 0; ar_wait <= 0; r_wait <= 0;
         aw_cap <= '0; w_cap <= '0; ws_cap <= '0; bresp_s <= OKAY; rresp_s <= OKAY;
         rdata_s <= '0; mtime_s <= '0; cmp_s <= '0; scr_s <= '0;
      end else begin
         mtime_s <= mtime_s + 1;
         a_now = aw_got || (axi.awvalid && axi.awready);
         w_now = w_got  || (axi.wvalid && axi.wready);
         wa  = aw_got ? aw_cap : axi.awaddr;
         wd  = w_got  ? w_cap  : axi.wdata;
         wsb = w_got  ? ws_cap : axi.wstrb;
         if (axi.awvalid && axi.awready) begin aw_got <= 1; aw_cap <= axi.awaddr; aw_wait <= 0; end
         else if (axi.awvalid) aw_wait <= aw_wait + 1;
         if (axi.wvalid && axi.wready) begin
            w_got <= 1; w_cap <= axi.wdata; ws_cap <= axi.wstrb; w_wait <= 0;
         end else if (axi.wvalid) w_wait <= w_wait + 1;
         if (a_now && w_now) begin
            aw_got <= 0; w_got <= 0; b_pend <= 1; b_wait <= 0;
            case (wa)
               32'h0000_0000: bresp_s <= OKAY;
               32'h0000_0008: begin cmp_s <= merge(cmp_s, wd, wsb); bresp_s <= OKAY; end
               32'h0000_000C: begin scr_s <= merge(scr_s, wd, wsb); bresp_s <= OKAY; end
               default:       bresp_s <= SLVERR;
            endcase
         end
         if (axi.bvalid && axi.bready) b_pend <= 0;
         else if (b_pend) b_wait <= b_wait + 1;
         if (axi.arvalid && axi.arready) begin
            r_pend <= 1; r_wait <= 0; ar_wait <= 0;
            case (axi.araddr)
               32'h0000_0000: begin rdata_s <= mtime_s; rresp_s <= OKAY; end
               32'h0000_0008: begin rdata_s <= cmp_s;   rresp_s <= OKAY; end
               32'h0000_000C: begin rdata_s <= scr_s;   rresp_s <= OKAY; end
               default:       begin rdata_s <= 32'hDEAD_BEEF; rresp_s <= SLVERR; end
            endcase
         end else if (axi.arvalid) ar_wait <= ar_wait + 1;
         if (axi.rvalid && axi.rready) r_pend <= 0;
         else if (r_pend) r_wait <= r_wait + 1;
      end
   end

   // ---------------- reference model and scoreboard
   typedef struct {
      logic  we;
      logic  err;
      data_t rdata;
      int    kind;   // 0 exact rdata, 1 monotonic MTIME, 2 rdata unknown
      int    gcyc;
      int    lat;
   } exp_t;

   exp_t  sb[$];
   data_t m_cmp = '0, m_scr = '0, m_last = '0, last_mtime = '0;
   bit    m_known = 1'b1;

   task automatic model(input logic we, input addr_t a, input strb_t be, input data_t wd, output exp_t e);
      addr_t wa = a & ~32'h3;
      e.we = we; e.kind = 0; e.rdata = '0; e.gcyc = 0;
      if (we) begin
         e.err = !(wa == 0 || wa == 8 || wa == 12);
         if (wa == 8)  m_cmp = merge(m_cmp, wd, be);
         if (wa == 12) m_scr = merge(m_scr, wd, be);
         e.rdata = m_last;
         e.kind  = m_known ? 0 : 2;
         e.lat   = 3 + imax(aw_dly, w_dly) + b_dly;
      end else begin
         e.lat = 3 + ar_dly + r_dly;
         e.err = 1'b0;
         if (wa == 0) begin e.kind = 1; m_known = 0; end
         else if (wa == 8)  e.rdata = m_cmp;
         else if (wa == 12) e.rdata = m_scr;
         else begin e.err = 1'b1; e.rdata = 32'h0000_0000; end
         if (wa != 0) begin m_last = e.rdata; m_known = 1; end
      end
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (!rst && data_rvalid) begin
         if (sb.size() == 0) begin
            chk("unexpected_rvalid", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            chk(e.we ? "wr_err" : "rd_err", {31'd0, data_err}, {31'd0, e.err});
            if (e.kind == 0) chk(e.we ? "wr_rdata_hold" : "rd_rdata", data_rdata, e.rdata);
            if (e.kind == 1) begin
               checks++;
               if (!(data_rdata > last_mtime)) begin
                  failures++;
                  $display("FAIL mtime_monotonic: got %h required > %h", data_rdata, last_mtime);
               end
               last_mtime = data_rdata;
            end
            chk("latency", cyc - e.gcyc, e.lat);
         end
      end
   end

   // ---------------- protocol monitor
   logic  pa = 0, pw = 0, pr = 0;
   addr_t paw, par;
   data_t pwd;
   strb_t pws;
   int    aw_hi = 0, w_hi = 0, b_hi = 0;

   always @(posedge clk) begin
      if (axi.awvalid) aw_hi++;
      if (axi.wvalid)  w_hi++;
      if (axi.bready)  b_hi++;
      if (rst) begin
         pa <= 0; pw <= 0; pr <= 0;
      end else begin
         if (pa) chk("aw_hold", {30'd0, axi.awvalid, axi.awaddr == paw}, 32'd3);
         if (pw) chk("w_hold", {30'd0, axi.wvalid, (axi.wdata == pwd) && (axi.wstrb == pws)}, 32'd3);
         if (pr) chk("ar_hold", {30'd0, axi.arvalid, axi.araddr == par}, 32'd3);
         if (axi.bvalid) chk("bvalid_in_wresp", {31'd0, axi.bready}, 32'd1);
         if (axi.rvalid) chk("rvalid_in_rresp", {31'd0, axi.rready}, 32'd1);
         if (axi.awvalid || axi.wvalid || axi.bready || axi.arvalid || axi.rready)
            chk("one_outstanding",
                {31'd0, (axi.awvalid || axi.wvalid || axi.bready) && (axi.arvalid || axi.rready)}, 32'd0);
         pa <= axi.awvalid && !axi.awready; paw <= axi.awaddr;
         pw <= axi.wvalid && !axi.wready;   pwd <= axi.wdata; pws <= axi.wstrb;
         pr <= axi.arvalid && !axi.arready; par <= axi.araddr;
      end
   end

   // ---------------- stimulus
   task automatic req(input logic we, input addr_t a, input strb_t be, input data_t wd, output int gc);
      exp_t e;
      int   n = 0;
      data_req = 1; data_we = we; data_addr = a; data_be = be; data_wdata = wd;
      @(negedge clk);
      while (!data_gnt && n < 200) begin @(negedge clk); n++; end
      if (!data_gnt) begin
         chk("gnt_timeout", 32'd0, 32'd1);
         data_req = 0; gc = -1;
         return;
      end
      gc = cyc;
      model(we, a, be, wd, e);
      e.gcyc = cyc;
      sb.push_back(e);
      @(posedge clk); #1;
      data_req = 0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (sb.size() != 0 && n < 500) begin @(negedge clk); n++; end
      if (sb.size() != 0) begin chk("resp_timeout", sb.size(), 32'd0); sb.delete(); end
      repeat (3) @(negedge clk);
      @(posedge clk); #1;
   endtask

   task automatic set_dly(input int a, input int w, input int b, input int ar, input int r);
      aw_dly = a; w_dly = w; b_dly = b; ar_dly = ar; r_dly = r;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, required < 200000 ns");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int g1, g2, n, sel;
      addr_t a;
      rst = 1; data_req = 0; data_we = 0; data_be = '0; data_addr = '0; data_wdata = '0;
      repeat (3) @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      chk("rst_gnt", {31'd0, data_gnt}, 32'd0);
      chk("rst_rvalid", {31'd0, data_rvalid}, 32'd0);
      chk("rst_err", {31'd0, data_err}, 32'd0);
      chk("rst_rdata", data_rdata, 32'd0);
      chk("rst_valids", {27'd0, axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}, 32'd0);
      chk("awprot", {29'd0, axi.awprot}, 32'd0);
      @(posedge clk); #1;

      // MTIMECMP write then read-back
      req(1, 32'h008, 4'hF, 32'h0000_1000, g1);
      req(0, 32'h008, 4'hF, 32'h0, g1);
      wait_idle();

      // back-to-back MTIME reads
      req(0, 32'h000, 4'hF, 32'h0, g1);
      req(0, 32'h000, 4'hF, 32'h0, g2);
      chk("b2b_grant_spacing", g2 - g1, 32'd3);
      wait_idle();

      // unmapped access
      req(1, 32'h010, 4'hF, 32'h1234_5678, g1);
      req(0, 32'h010, 4'hF, 32'h0, g1);
      wait_idle();

      // AW backpressure, W immediate
      set_dly(4, 0, 0, 0, 0);
      aw_hi = 0; w_hi = 0;
      req(1, 32'h00C, 4'h5, $urandom, g1);
      wait_idle();
      chk("aw_valid_cycles", aw_hi, 32'd5);
      chk("w_valid_cycles", w_hi, 32'd1);

      // W backpressure, AW immediate, late B
      set_dly(0, 3, 3, 0, 0);
      aw_hi = 0; w_hi = 0; b_hi = 0;
      req(1, 32'h008, 4'hF, $urandom, g1);
      wait_idle();
      chk("aw_valid_cycles2", aw_hi, 32'd1);
      chk("w_valid_cycles2", w_hi, 32'd4);
      chk("bready_cycles", b_hi, 32'd4);

      // randomized batches, one backpressure setting per batch
      for (int b = 0; b < 6; b++) begin
         if (b == 0) set_dly(0, 0, 0, 0, 0);
         else set_dly($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 3));
         for (int t = 0; t < 12; t++) begin
            sel = $urandom_range(0, 5);
            case (sel)
               0: a = 32'h000;
               1: a = 32'h004;
               2: a = 32'h008;
               3: a = 32'h00C;
               4: a = 32'h010;
               default: a = 32'h8000_0000 | $urandom;
            endcase
            a = a | $urandom_range(0, 3);
            req($urandom_range(0, 1), a, 4'($urandom_range(1, 15)), $urandom, g1);
         end
         wait_idle();
      end

      // reset while waiting for B
      set_dly(0, 0, 10, 0, 0);
      req(1, 32'h008, 4'hF, 32'hAAAA_5555, g1);
      n = 0;
      while (!axi.bready && n < 50) begin @(negedge clk); n++; end
      chk("reached_wresp", {31'd0, axi.bready}, 32'd1);
      @(posedge clk); #1 rst = 1;
      @(posedge clk); #1 rst = 0;
      sb.delete();
      m_cmp = '0; m_scr = '0; m_last = '0; m_known = 1; last_mtime = '0;
      set_dly(0, 0, 0, 0, 0);
      @(negedge clk);
      chk("post_rst_valids", {27'd0, axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}, 32'd0);
      chk("post_rst_rvalid", {31'd0, data_rvalid}, 32'd0);
      chk("post_rst_rdata", data_rdata, 32'd0);
      repeat (4) @(negedge clk);
      @(posedge clk); #1;
      req(0, 32'h008, 4'hF, 32'h0, g1);
      wait_idle();

      chk("scoreboard_drained", sb.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
